// File: rtl/alu_div_pkg.sv
// Shared definitions for the sequential MIPS32 divider: state encoding,
// default operand width and the iteration-counter width.
package alu_div_pkg;

  localparam int DIV_WIDTH = 32;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_seq_unit_if.sv
// Request/result bundle between the datapath controller (master) and the
// sequential divider (slave).
interface div_seq_unit_if #(
  parameter int WIDTH = alu_div_pkg::DIV_WIDTH
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divByZero;
  logic             overflowDiv;

  modport master (
    output start, signed_op, A, B,
    input  busy, done, quotient, remainder, divByZero, overflowDiv
  );

  modport slave (
    input  start, signed_op, A, B,
    output busy, done, quotient, remainder, divByZero, overflowDiv
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor and keep the difference if it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // zero and WIDTH+1 bits are enough for a sign-correct trial.
  assign unused_rem_msb = rem_i[WIDTH];
  assign shifted        = {rem_i[WIDTH-1:0], bit_i};
  assign trial          = shifted - {1'b0, divisor_i};
  assign q_o            = ~trial[WIDTH];
  assign rem_o          = q_o ? trial : shifted;

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle restoring divider for MIPS32 div/divu; drives HI/LO results.
// Define DIV_SIGNED_EN to honour signed_op (sign fix-up and overflowDiv).
module div_seq_unit
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic           clk,
  input logic           rst,
  div_seq_unit_if.slave bus
);

  localparam int             CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] qacc_q, qacc_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             is_dbz, is_ovf;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_next;
  logic             busy, done;
  logic             unused_step_msb;

`ifdef DIV_SIGNED_EN
  assign sgn = bus.signed_op;
`else
  logic unused_signed_op;
  assign unused_signed_op = bus.signed_op;
  assign sgn              = 1'b0;
`endif

  // Divide on magnitudes; the most negative value maps onto 2^(WIDTH-1).
  assign a_neg  = sgn & bus.A[WIDTH-1];
  assign b_neg  = sgn & bus.B[WIDTH-1];
  assign a_mag  = a_neg ? -bus.A : bus.A;
  assign b_mag  = b_neg ? -bus.B : bus.B;
  assign is_dbz = (bus.B == '0);
  assign is_ovf = sgn && (bus.A == MIN_NEG) && (bus.B == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (qacc_q[WIDTH-1]),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign q_next          = {qacc_q[WIDTH-2:0], step_q};
  assign unused_step_msb = step_rem[WIDTH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    qacc_d      = qacc_q;
    dvsr_d      = dvsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy  = 1'b1;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (is_dbz) begin
            quotient_d  = '1;
            remainder_d = bus.A;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end else if (is_ovf) begin
            quotient_d  = MIN_NEG;
            remainder_d = '0;
            ovf_d       = 1'b1;
            state_d     = S_DONE;
          end else begin
            rem_d     = '0;
            qacc_d    = a_mag;
            dvsr_d    = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        busy   = 1'b1;
        rem_d  = step_rem;
        qacc_d = q_next;
        cnt_d  = cnt_q + CW'(1);
        // Results are committed on the last step so they are valid with done.
        if (cnt_q == LAST) begin
          quotient_d  = neg_quo_q ? -q_next : q_next;
          remainder_d = neg_rem_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      qacc_q      <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      qacc_q      <= qacc_d;
      dvsr_q      <= dvsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.divByZero   = dbz_q;
  assign bus.overflowDiv = ovf_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Scoreboard bench for div_seq_unit: expected results are queued on start
// and compared when done pulses.
module tb_div_seq_unit;
  import alu_div_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  div_seq_unit_if #(.WIDTH(W)) bus ();

  div_seq_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   sa, sbv;
    logic sg;
`ifdef DIV_SIGNED_EN
    sg = s;
`else
    sg = 1'b0;
`endif
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = W + 1;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = '0; e.ovf = 1'b1; e.lat = 1;
    end else if (sg) begin
      sa = a; sbv = b;
      e.q = sa / sbv;
      e.r = sa % sbv;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   c;
    bit   got;
    sb.push_back(model(a, b, s));
    bus.A = a; bus.B = b; bus.signed_op = s; bus.start = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL busy_accept got=%b exp=1", bus.busy);
    end
    c = 0; got = 0;
    while (!got && c < 100) begin
      @(negedge clk); c++;
      if (c == 1) begin
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== (sb[0].lat != 1)) begin
          errors++; $display("FAIL busy_cycle1 got=%b exp=%b", bus.busy, sb[0].lat != 1);
        end
      end
      if (bus.done === 1'b1) got = 1;
    end
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++; $display("FAIL done_timeout a=%h b=%h cycles=%0d", a, b, c);
      return;
    end
    if (c != e.lat) begin
      errors++; $display("FAIL latency got=%0d exp=%0d", c, e.lat);
    end
    checks += 4;
    if (bus.quotient !== e.q) begin
      errors++; $display("FAIL quotient a=%h b=%h s=%b got=%h exp=%h", a, b, s, bus.quotient, e.q);
    end
    if (bus.remainder !== e.r) begin
      errors++; $display("FAIL remainder a=%h b=%h s=%b got=%h exp=%h", a, b, s, bus.remainder, e.r);
    end
    if (bus.divByZero !== e.dbz) begin
      errors++; $display("FAIL divByZero got=%b exp=%b", bus.divByZero, e.dbz);
    end
    if (bus.overflowDiv !== e.ovf) begin
      errors++; $display("FAIL overflowDiv got=%b exp=%b", bus.overflowDiv, e.ovf);
    end
    $display("op a=%h b=%h s=%b -> q=%h r=%h dbz=%b ovf=%b lat=%0d",
             a, b, s, bus.quotient, bus.remainder, bus.divByZero, bus.overflowDiv, c);
    @(negedge clk);
    checks += 2;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL done_pulse got=%b exp=0", bus.done);
    end
    if (bus.quotient !== e.q) begin
      errors++; $display("FAIL result_hold got=%h exp=%h", bus.quotient, e.q);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.divByZero, bus.overflowDiv} !== 4'b0 ||
        bus.quotient !== '0 || bus.remainder !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b q=%h r=%h dbz=%b ovf=%b exp=all0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.divByZero, bus.overflowDiv);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_unsigned();
    do_op(32'd100, 32'd7, 1'b0);
    do_op(32'd0, 32'd5, 1'b0);
    do_op(32'd5, 32'd7, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 4; i++) do_op($urandom, $urandom_range(1, 65535), 1'b0);
  endtask

  task automatic test_div_by_zero();
    do_op(32'd5, 32'd0, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd0, 1'b1);
  endtask

  task automatic test_signed();
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    do_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
    do_op(32'd100, 32'd7, 1'b1);
    do_op(32'h8000_0000, 32'd1, 1'b1);
    for (int i = 0; i < 4; i++) do_op($urandom, $urandom | 32'd1, 1'b1);
  endtask

  task automatic test_overflow();
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   c;
    bit   got;
    sb.push_back(model(32'd100, 32'd7, 1'b0));
    bus.A = 32'd100; bus.B = 32'd7; bus.signed_op = 1'b0; bus.start = 1'b1;
    c = 0; got = 0;
    while (!got && c < 100) begin
      @(negedge clk); c++;
      bus.start = (c == 10);
      if (c == 10) begin bus.A = 32'd9; bus.B = 32'd3; end
      if (bus.done === 1'b1) got = 1;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    checks += 3;
    if (!got || c != e.lat) begin
      errors++; $display("FAIL ignore_latency got=%0d exp=%0d", c, e.lat);
    end
    if (bus.quotient !== e.q) begin
      errors++; $display("FAIL ignore_quotient got=%h exp=%h", bus.quotient, e.q);
    end
    if (bus.remainder !== e.r) begin
      errors++; $display("FAIL ignore_remainder got=%h exp=%h", bus.remainder, e.r);
    end
    $display("ignore-start op q=%h r=%h lat=%0d", bus.quotient, bus.remainder, c);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_op(32'd1000, 32'd33, 1'b0);
    do_op(32'd12345, 32'd1, 1'b0);
    do_op(32'd42, 32'd0, 1'b0);
    do_op(32'd77, 32'd77, 1'b0);
  endtask

  task automatic test_reset_abort();
    bit saw;
    bus.A = 32'd100; bus.B = 32'd7; bus.signed_op = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.divByZero, bus.overflowDiv} !== 4'b0 ||
        bus.quotient !== '0 || bus.remainder !== '0) begin
      errors++;
      $display("FAIL abort_clear busy=%b done=%b q=%h r=%h exp=all0",
               bus.busy, bus.done, bus.quotient, bus.remainder);
    end
    saw = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw = 1;
    end
    checks++;
    if (saw) begin
      errors++; $display("FAIL abort_done got=1 exp=0");
    end
    $display("reset abort checked");
    do_op(32'd1000, 32'd10, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_div_by_zero();
    test_signed();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
